// File: rtl/cic_decim_n_if.sv
// Sample-in / decimated-out bundle of the CIC decimator.
// The producer side drives the samples and ratio request; the decimator drives the results.
interface cic_decim_n_if #(
    parameter int BIT = 12,
    parameter int W   = 30,
    parameter int DW  = 3
);
    logic           IN_VLD;
    logic [BIT-1:0] RECOV_DATA;
    logic [DW-1:0]  DEC_SEL;
    logic [W-1:0]   CIC_OUT;
    logic [BIT:0]   CIC_NORM;
    logic           OUT_VLD;
    logic [DW-1:0]  DEC_ACT;

    modport master (
        output IN_VLD, RECOV_DATA, DEC_SEL,
        input  CIC_OUT, CIC_NORM, OUT_VLD, DEC_ACT
    );

    modport slave (
        input  IN_VLD, RECOV_DATA, DEC_SEL,
        output CIC_OUT, CIC_NORM, OUT_VLD, DEC_ACT
    );
endinterface

// File: rtl/cic_decim_n.sv
// N-th order CIC decimator running entirely on FADC, with runtime ratio R = 2^DEC_ACT.
// Integrators and combs use modulo-2^W arithmetic; the decimation tick is an internal strobe.
module cic_decim_n #(
    parameter int ORDER     = 3,
    parameter int OSR_MAX   = 64,
    parameter int BIT       = 12,
    parameter int SIGNED_IN = 0,
    localparam int SW       = $clog2(OSR_MAX),
    localparam int W        = BIT + ORDER * SW,
    localparam int DW       = $clog2(SW + 1)
) (
    input logic          FADC,
    input logic          RST_SN,
    cic_decim_n_if.slave bus
);
    localparam int STW = $clog2(ORDER + 1);

    logic [W-1:0]   integ     [ORDER];
    logic [W-1:0]   integ_nxt [ORDER];
    logic [W-1:0]   ext_data;
    logic           ext_sign;

    logic           armed;
    logic [DW-1:0]  dec_q;
    logic [DW-1:0]  dec_act;
    logic [DW-1:0]  dec_clamp;
    logic [SW-1:0]  dcnt;
    logic [SW-1:0]  r_max;
    logic           tick;
    logic           ratio_chg;
    logic [STW-1:0] settle;

    logic [W-1:0]   cin;
    logic           cin_vld;
    logic           cin_keep;
    logic [DW-1:0]  cin_sh;

    logic [W-1:0]   comb_c    [ORDER];
    logic [W-1:0]   comb_d    [ORDER];
    logic           comb_vld  [ORDER];
    logic           comb_keep [ORDER];
    logic [DW-1:0]  comb_sh   [ORDER];
    logic [W-1:0]   x_data    [ORDER];
    logic           x_vld     [ORDER];
    logic           x_keep    [ORDER];
    logic [DW-1:0]  x_sh      [ORDER];

    logic [W-1:0]   cic_out;
    logic [BIT:0]   cic_norm;
    logic           out_vld;

    always_comb begin
        dec_clamp = bus.DEC_SEL;
        if (bus.DEC_SEL == '0) begin
            dec_clamp = DW'(1);
        end else if (bus.DEC_SEL > DW'(SW)) begin
            dec_clamp = DW'(SW);
        end
    end

    // Until the first edge after reset release the ratio tracks DEC_SEL directly,
    // so DEC_ACT reflects the value present at release without an async load from an input.
    assign dec_act = armed ? dec_q : dec_clamp;

    always_comb begin
        r_max = '0;
        for (int i = 0; i < SW; i++) begin
            r_max[i] = (i < int'(dec_act));
        end
    end

    assign tick      = bus.IN_VLD && (dcnt == r_max);
    assign ratio_chg = tick && (dec_clamp != dec_act);

    assign ext_sign = (SIGNED_IN != 0) && bus.RECOV_DATA[BIT-1];
    assign ext_data = {{(W - BIT){ext_sign}}, bus.RECOV_DATA};

    always_comb begin
        integ_nxt[0] = integ[0] + ext_data;
        for (int k = 1; k < ORDER; k++) begin
            integ_nxt[k] = integ[k] + integ[k-1];
        end
    end

    always_ff @(posedge FADC or negedge RST_SN) begin
        if (!RST_SN) begin
            for (int k = 0; k < ORDER; k++) begin
                integ[k] <= '0;
            end
        end else if (bus.IN_VLD) begin
            for (int k = 0; k < ORDER; k++) begin
                integ[k] <= integ_nxt[k];
            end
        end
    end

    // The keep/discard decision is made at capture time and travels with the sample,
    // so outputs still in flight from before a ratio change are unaffected by it.
    always_ff @(posedge FADC or negedge RST_SN) begin
        if (!RST_SN) begin
            armed    <= 1'b0;
            dec_q    <= '0;
            dcnt     <= '0;
            settle   <= STW'(ORDER);
            cin      <= '0;
            cin_vld  <= 1'b0;
            cin_keep <= 1'b0;
            cin_sh   <= '0;
        end else begin
            if (!armed) begin
                armed <= 1'b1;
                dec_q <= dec_clamp;
            end else if (ratio_chg) begin
                dec_q <= dec_clamp;
            end
            if (bus.IN_VLD) begin
                dcnt <= tick ? '0 : dcnt + 1'b1;
            end
            cin_vld <= tick;
            if (tick) begin
                cin    <= integ_nxt[ORDER-1];
                cin_sh <= dec_act;
                if (ratio_chg) begin
                    cin_keep <= 1'b0;
                    settle   <= STW'(ORDER - 1);
                end else if (settle != '0) begin
                    cin_keep <= 1'b0;
                    settle   <= settle - 1'b1;
                end else begin
                    cin_keep <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        x_data[0] = cin;
        x_vld[0]  = cin_vld;
        x_keep[0] = cin_keep;
        x_sh[0]   = cin_sh;
        for (int k = 1; k < ORDER; k++) begin
            x_data[k] = comb_c[k-1];
            x_vld[k]  = comb_vld[k-1];
            x_keep[k] = comb_keep[k-1];
            x_sh[k]   = comb_sh[k-1];
        end
    end

    always_ff @(posedge FADC or negedge RST_SN) begin
        if (!RST_SN) begin
            for (int k = 0; k < ORDER; k++) begin
                comb_c[k]    <= '0;
                comb_d[k]    <= '0;
                comb_vld[k]  <= 1'b0;
                comb_keep[k] <= 1'b0;
                comb_sh[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < ORDER; k++) begin
                comb_vld[k]  <= x_vld[k];
                comb_keep[k] <= x_keep[k];
                comb_sh[k]   <= x_sh[k];
                if (x_vld[k]) begin
                    comb_c[k] <= x_data[k] - comb_d[k];
                    comb_d[k] <= x_data[k];
                end
            end
        end
    end

    always_ff @(posedge FADC or negedge RST_SN) begin
        if (!RST_SN) begin
            out_vld  <= 1'b0;
            cic_out  <= '0;
            cic_norm <= '0;
        end else begin
            out_vld <= comb_vld[ORDER-1] && comb_keep[ORDER-1];
            if (comb_vld[ORDER-1] && comb_keep[ORDER-1]) begin
                cic_out  <= comb_c[ORDER-1];
                cic_norm <= (BIT + 1)'($signed(comb_c[ORDER-1]) >>> (ORDER * int'(comb_sh[ORDER-1])));
            end
        end
    end

    assign bus.CIC_OUT  = cic_out;
    assign bus.CIC_NORM = cic_norm;
    assign bus.OUT_VLD  = out_vld;
    assign bus.DEC_ACT  = dec_act;
endmodule
